rgb_grey_packer: RTL and testbench

//  Pipelined RGB->greyscale converter for the camera datapath. Replaces the divide-based

---
 rtl/rgb_grey_packer.sv | 214 +++++++++++++++++++++
 tb/tb_rgb_grey_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_grey_packer.sv
// rgb_grey_packer
//   Pipelined RGB -> greyscale converter with frame/pixel gating and packing of
//   PIX_PER_WORD grey pixels per output word. Sits between the demosaic output
//   and the frame-buffer write path.
//
//   Pipeline (pixel sampled at edge N):
//     S1 (edge N)   : per-colour products and valid/tag bits
//     S2 (edge N+1) : sum, >>COEF_SHIFT, keep GREY_BITS MSBs
//     S3 (edge N+2) : packer slot buffer / slot counter
//     OUT (edge N+3): data_out / out_valid / frame_start / frame_end
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   red/green/blue_input       NUM_BITS_RGB colour samples
//   f_val, d_val               frame valid, pixel valid (d_val qualified by f_val)
//   data_out                   packed grey word, first pixel in the LSBs
//   out_valid                  1-cycle strobe, data_out holds a new word
//   frame_start                with out_valid of the first word of a frame
//   frame_end                  1-cycle strobe, frame complete (may coincide with out_valid)
//   pix_count                  accepted pixels in current/last frame, saturating
//
// Optional build macro GREY_CHECK_EN adds grey_check (full-precision S2 grey)
// and grey_check_valid (S2 valid) probe outputs.
module rgb_grey_packer #(
  parameter int NUM_BITS_RGB = 12,
  parameter int GREY_BITS    = 10,
  parameter int PIX_PER_WORD = 2,
  parameter int COEF_R       = 1224,
  parameter int COEF_G       = 2404,
  parameter int COEF_B       = 467,
  parameter int COEF_SHIFT   = 12,
  parameter int CNT_BITS     = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_BITS_RGB-1:0]           red_input,
  input  logic [NUM_BITS_RGB-1:0]           green_input,
  input  logic [NUM_BITS_RGB-1:0]           blue_input,
  input  logic                              f_val,
  input  logic                              d_val,
  output logic [PIX_PER_WORD*GREY_BITS-1:0] data_out,
  output logic                              out_valid,
  output logic                              frame_start,
  output logic                              frame_end,
`ifdef GREY_CHECK_EN
  output logic [NUM_BITS_RGB-1:0]           grey_check,
  output logic                              grey_check_valid,
`endif
  output logic [CNT_BITS-1:0]               pix_count
);

  localparam int CW = COEF_SHIFT + 1;            // coefficients are <= 2^COEF_SHIFT
  localparam int PW = NUM_BITS_RGB + CW;         // product width
  localparam int SW = PW + 2;                    // sum of three products
  localparam int KW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [PW-1:0] CR = PW'(COEF_R);
  localparam logic [PW-1:0] CG = PW'(COEF_G);
  localparam logic [PW-1:0] CB = PW'(COEF_B);

  // ---------------------------------------------------------------- gating
  logic f_val_q, in_frame_q, first_pend;
  logic rise, in_frame, accept, first_pix;

  // f_val_q comes out of reset high so an f_val already high at release is
  // not mistaken for a frame start; a real 0->1 edge is required.
  assign rise      = f_val & ~f_val_q;
  assign in_frame  = f_val & (in_frame_q | rise);
  assign accept    = in_frame & d_val;
  assign first_pix = accept & (rise | first_pend);

  always_ff @(posedge clk) begin
    if (reset) begin
      f_val_q    <= 1'b1;
      in_frame_q <= 1'b0;
      first_pend <= 1'b0;
    end else begin
      f_val_q    <= f_val;
      in_frame_q <= in_frame;
      first_pend <= (rise | first_pend) & ~accept;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      pix_count <= '0;
    else if (rise)
      pix_count <= CNT_BITS'(accept);
    else if (accept && pix_count != '1)
      pix_count <= pix_count + CNT_BITS'(1);
  end

  // ---------------------------------------------------------------- S1
  logic [PW-1:0] pr, pg, pb;
  logic          v1, first1, fv1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pr <= '0; pg <= '0; pb <= '0;
      v1 <= 1'b0; first1 <= 1'b0; fv1 <= 1'b0;
    end else begin
      pr     <= PW'(red_input)   * CR;
      pg     <= PW'(green_input) * CG;
      pb     <= PW'(blue_input)  * CB;
      v1     <= accept;
      first1 <= first_pix;
      fv1    <= in_frame;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [SW-1:0]           sum;
  logic [NUM_BITS_RGB-1:0] grey_full;
  logic [GREY_BITS-1:0]    grey2;
  logic                    v2, first2, fv2;

  always_comb begin
    sum       = SW'(pr) + SW'(pg) + SW'(pb);
    grey_full = sum[COEF_SHIFT +: NUM_BITS_RGB];   // truncating shift
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grey2 <= '0; v2 <= 1'b0; first2 <= 1'b0; fv2 <= 1'b0;
    end else begin
      grey2  <= grey_full[NUM_BITS_RGB-1 -: GREY_BITS];
      v2     <= v1;
      first2 <= first1;
      fv2    <= fv1;
    end
  end

`ifdef GREY_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grey_check       <= '0;
      grey_check_valid <= 1'b0;
    end else begin
      grey_check       <= grey_full;
      grey_check_valid <= v1;
    end
  end
`endif

  // Bits of the sum outside the kept window are dropped by design.
  logic unused_bits;
  assign unused_bits = ^{sum[SW-1:COEF_SHIFT+NUM_BITS_RGB], sum[COEF_SHIFT-1:0],
                         grey_full[NUM_BITS_RGB-GREY_BITS-1:0]};

  // ---------------------------------------------------------------- S3 packer
  // The frame fall is taken from the gate delayed one stage less than the
  // pixel data, so the fall lines up with the S2 slot of the last pixel that
  // could have been accepted (the one sampled just before f_val dropped).
  logic                                  fall;
  logic [PIX_PER_WORD-1:0][GREY_BITS-1:0] pbuf, buf_n, word_q;
  logic [KW-1:0]                         k, k_n;
  logic                                  full, emit, start_pend, start_now;
  logic                                  emit_q, end_q, start_q;

  assign fall      = fv2 & ~fv1;
  assign start_now = start_pend | (v2 & first2);

  always_comb begin
    buf_n = pbuf;
    k_n   = k;
    full  = 1'b0;
    if (v2) begin
      for (int s = 0; s < PIX_PER_WORD; s++)
        if (k == KW'(s)) buf_n[s] = grey2;
      full = (k == KW'(PIX_PER_WORD - 1));
      k_n  = full ? '0 : k + KW'(1);
    end
    // Flush only when the group holds something; the buffer is cleared after
    // every emit, so the unused upper slots are already zero.
    emit = full | (fall & (v2 | (k != '0)));
    if (emit) k_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pbuf       <= '0;
      k          <= '0;
      word_q     <= '0;
      emit_q     <= 1'b0;
      end_q      <= 1'b0;
      start_q    <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      pbuf       <= emit ? '0 : buf_n;
      k          <= k_n;
      word_q     <= buf_n;
      emit_q     <= emit;
      end_q      <= fall;
      start_q    <= start_now;
      start_pend <= emit ? 1'b0 : start_now;
    end
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      if (emit_q) data_out <= word_q;
      out_valid   <= emit_q;
      frame_start <= emit_q & start_q;
      frame_end   <= end_q;
    end
  end

endmodule

// File: tb/tb_rgb_grey_packer.sv
module tb_rgb_grey_packer;
  localparam int NB = 12;
  localparam int WW = 20;
  localparam int CB = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] red, green, blue;
  logic          f_val, d_val;
  logic [WW-1:0] data_out;
  logic          out_valid, frame_start, frame_end;
  logic [CB-1:0] pix_count;
`ifdef GREY_CHECK_EN
  logic [NB-1:0] grey_check;
  logic          grey_check_valid;
`endif

  rgb_grey_packer dut (
    .clk(clk), .reset(reset),
    .red_input(red), .green_input(green), .blue_input(blue),
    .f_val(f_val), .d_val(d_val),
    .data_out(data_out), .out_valid(out_valid),
    .frame_start(frame_start), .frame_end(frame_end),
`ifdef GREY_CHECK_EN
    .grey_check(grey_check), .grey_check_valid(grey_check_valid),
`endif
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Hand-computed words: white grey = 4094 -> 10 MSBs 0x3FF; black = 0;
  // red 4095 -> 1223 -> 305; green 4095 -> 2403 -> 600.
  localparam logic [WW-1:0] W_WB = 20'h003FF;
  localparam logic [WW-1:0] W_WW = 20'hFFFFF;
  localparam logic [WW-1:0] W_RG = {10'd600, 10'd305};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pix(input logic [NB-1:0] r, input logic [NB-1:0] g,
                     input logic [NB-1:0] b, input logic fv, input logic dv);
    red = r; green = g; blue = b; f_val = fv; d_val = dv;
  endtask

  // Drop f_val on a frame whose words are all out; expect frame_end alone.
  task automatic end_frame(input string name);
    bit seen = 0;
    pix(0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (frame_end) begin
        seen = 1;
        n_chk++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_end: out_valid=%b with frame_end, required 0", name, out_valid);
        end
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_end: frame_end not seen within 8 cycles, required 1", name);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pix(NB'($urandom), NB'($urandom), NB'($urandom), i[0], 1'b1);
      tick();
      n_chk++;
      if ({data_out, out_valid, frame_start, frame_end, pix_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: data_out=%h ov=%b fs=%b fe=%b pc=%0d, required all 0",
                 data_out, out_valid, frame_start, frame_end, pix_count);
      end
    end
    // f_val already high at release: not a frame start.
    pix(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0 || pix_count !== '0) begin
        n_fail++;
        $display("FAIL reset_no_rise: ov=%b pc=%0d, required 0/0", out_valid, pix_count);
      end
    end
    pix(0, 0, 0, 1'b0, 1'b0);
    tick(); tick();
  endtask

  task automatic test_basic_frame();
    pix(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1); tick();
    pix(12'd0, 12'd0, 12'd0, 1'b1, 1'b1);           tick();  // edge N
    pix(12'd0, 12'd0, 12'd0, 1'b1, 1'b0);
    tick(); tick();                                          // N+2
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: out_valid=%b after N+2, required 0", out_valid);
    end
    tick();                                                  // N+3
    n_chk++;
    if (out_valid !== 1'b1 || data_out !== W_WB || frame_start !== 1'b1 || pix_count !== 24'd2) begin
      n_fail++;
      $display("FAIL basic_word: ov=%b data=%h fs=%b pc=%0d, required 1/%h/1/2",
               out_valid, data_out, frame_start, pix_count, W_WB);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || data_out !== W_WB || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: ov=%b data=%h fs=%b, required 0/%h/0",
               out_valid, data_out, frame_start, W_WB);
    end
    end_frame("basic");
  endtask

  task automatic test_colour();
    pix(12'd4095, 12'd0, 12'd0, 1'b1, 1'b1); tick();
    pix(12'd0, 12'd4095, 12'd0, 1'b1, 1'b1); tick();
    pix(12'd0, 12'd0, 12'd0, 1'b1, 1'b0);
    tick(); tick(); tick();
    n_chk++;
    if (out_valid !== 1'b1 || data_out !== W_RG || frame_start !== 1'b1 || pix_count !== 24'd2) begin
      n_fail++;
      $display("FAIL colour_word: ov=%b data=%h fs=%b pc=%0d, required 1/%h/1/2",
               out_valid, data_out, frame_start, pix_count, W_RG);
    end
    end_frame("colour");
  endtask

  task automatic test_flush();
    // odd count: second word flushed with zero fill together with frame_end
    for (int i = 0; i < 3; i++) begin
      pix(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1); tick();
    end
    pix(0, 0, 0, 1'b0, 1'b0);
    tick(); tick();                                          // N+2
    n_chk++;
    if (out_valid !== 1'b1 || data_out !== W_WW || frame_start !== 1'b1 || frame_end !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_word1: ov=%b data=%h fs=%b fe=%b, required 1/%h/1/0",
               out_valid, data_out, frame_start, frame_end, W_WW);
    end
    tick();                                                  // N+3
    n_chk++;
    if (out_valid !== 1'b1 || data_out !== W_WB || frame_end !== 1'b1 ||
        frame_start !== 1'b0 || pix_count !== 24'd3) begin
      n_fail++;
      $display("FAIL flush_word2: ov=%b data=%h fe=%b fs=%b pc=%0d, required 1/%h/1/0/3",
               out_valid, data_out, frame_end, frame_start, pix_count, W_WB);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || frame_end !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: ov=%b fe=%b, required 0/0", out_valid, frame_end);
    end
    // d_val between frames is ignored; count holds after frame_end
    pix(12'd4095, 12'd4095, 12'd4095, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    n_chk++;
    if (pix_count !== 24'd3 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_dval: pc=%0d ov=%b, required 3/0", pix_count, out_valid);
    end
    // even count: word and frame_end together, no extra flush word
    for (int i = 0; i < 2; i++) begin
      pix(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1); tick();
    end
    pix(0, 0, 0, 1'b0, 1'b0);
    tick(); tick();                                          // N+2
    n_chk++;
    if (out_valid !== 1'b0 || frame_end !== 1'b0) begin
      n_fail++;
      $display("FAIL even_early: ov=%b fe=%b, required 0/0", out_valid, frame_end);
    end
    tick();                                                  // N+3
    n_chk++;
    if (out_valid !== 1'b1 || data_out !== W_WW || frame_end !== 1'b1 ||
        frame_start !== 1'b1 || pix_count !== 24'd2) begin
      n_fail++;
      $display("FAIL even_word: ov=%b data=%h fe=%b fs=%b pc=%0d, required 1/%h/1/1/2",
               out_valid, data_out, frame_end, frame_start, pix_count, W_WW);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || frame_end !== 1'b0) begin
      n_fail++;
      $display("FAIL even_no_flush: ov=%b fe=%b, required 0/0", out_valid, frame_end);
    end
    tick();
  endtask

  task automatic test_gap();
    pix(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1); tick();
    pix(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b0); tick(); tick();
    pix(12'd0, 12'd0, 12'd0, 1'b1, 1'b1);           tick();  // edge N
    pix(12'd0, 12'd0, 12'd0, 1'b1, 1'b0);
    tick(); tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_early: out_valid=%b after N+2, required 0", out_valid);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || data_out !== W_WB || frame_start !== 1'b1 || pix_count !== 24'd2) begin
      n_fail++;
      $display("FAIL gap_word: ov=%b data=%h fs=%b pc=%0d, required 1/%h/1/2",
               out_valid, data_out, frame_start, pix_count, W_WB);
    end
    end_frame("gap");
  endtask

  task automatic test_mid_reset();
    bit bad = 0;
    pix(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1); tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pix(NB'($urandom), NB'($urandom), NB'($urandom), 1'b1, 1'b1);
      tick();
      if (out_valid !== 1'b0 || frame_end !== 1'b0 || pix_count !== '0) bad = 1;
    end
    pix(0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b0 || frame_end !== 1'b0 || pix_count !== '0) bad = 1;
    end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL midreset_quiet: output or count seen before f_val rise, required none");
    end
    pix(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1); tick();
    pix(12'd0, 12'd0, 12'd0, 1'b1, 1'b1);           tick();
    pix(12'd0, 12'd0, 12'd0, 1'b1, 1'b0);
    tick(); tick(); tick();
    n_chk++;
    if (out_valid !== 1'b1 || data_out !== W_WB || frame_start !== 1'b1 || pix_count !== 24'd2) begin
      n_fail++;
      $display("FAIL midreset_word: ov=%b data=%h fs=%b pc=%0d, required 1/%h/1/2",
               out_valid, data_out, frame_start, pix_count, W_WB);
    end
    end_frame("midreset");
  endtask

  initial begin
    pix(0, 0, 0, 1'b0, 1'b0);
    test_reset();
    test_basic_frame();
    test_colour();
    test_flush();
    test_gap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
